// File: rtl/calc_pkg.sv
// Shared types for the calculator operand-entry block: operand width,
// operand-status states and the key-event priority encoding.
package calc_pkg;

  localparam int CALC_NUM_W = 7;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    A_ONLY = 2'd1,
    B_ONLY = 2'd2,
    BOTH   = 2'd3
  } op_state_t;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_CLEAR  = 2'd1,
    EV_LOAD_A = 2'd2,
    EV_LOAD_B = 2'd3
  } op_event_t;

  // Clear beats load_a, load_a beats load_b; losers are dropped.
  function automatic op_event_t encode_event(input logic clr, input logic ld_a,
                                             input logic ld_b);
    if (clr)       return EV_CLEAR;
    else if (ld_a) return EV_LOAD_A;
    else if (ld_b) return EV_LOAD_B;
    else           return EV_NONE;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key conditioner: 2-flop sync, hold-time debounce and a
// one-cycle press strobe on the stable 1->0 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_dly;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      stable     <= 1'b1;
      stable_dly <= 1'b1;
      cnt        <= '0;
      press      <= 1'b0;
    end else begin
      sync1      <= key_n;
      sync2      <= sync1;
      stable_dly <= stable;
      press      <= stable_dly & ~stable;
      // Flip only once the mismatch has been seen DEBOUNCE_CYCLES times in a row.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/calc_operand_entry.sv
// Operand entry for the calculator: synchronizes switches, debounces the
// load/clear keys, captures num1/num2 and tracks which operands are loaded.
import calc_pkg::*;

module calc_operand_entry #(
  parameter int NUM_W           = CALC_NUM_W,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_W-1:0] sw_num,
  input  logic             sw_cal_mode,
  input  logic             sw_disp_mode,
  input  logic             key_load_a_n,
  input  logic             key_load_b_n,
  input  logic             key_clear_n,
  output logic [NUM_W-1:0] num1,
  output logic [NUM_W-1:0] num2,
  output logic             cal_mode,
  output logic             disp_mode,
  output logic             ready,
  output logic             load_pulse
);

  logic [NUM_W-1:0] num_s1;
  logic [NUM_W-1:0] num_s2;
  logic             cal_s1;
  logic             disp_s1;
  logic             ev_load_a;
  logic             ev_load_b;
  logic             ev_clear;

  op_state_t        state_q;
  op_state_t        state_d;
  op_event_t        ev;
  logic [NUM_W-1:0] num1_d;
  logic [NUM_W-1:0] num2_d;
  logic             load_pulse_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .rst_n(rst_n), .key_n(key_load_a_n), .press(ev_load_a)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .rst_n(rst_n), .key_n(key_load_b_n), .press(ev_load_b)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
    .clk(clk), .rst_n(rst_n), .key_n(key_clear_n), .press(ev_clear)
  );

  // Mode switches are only synchronized, not debounced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_s1    <= '0;
      num_s2    <= '0;
      cal_s1    <= 1'b0;
      cal_mode  <= 1'b0;
      disp_s1   <= 1'b0;
      disp_mode <= 1'b0;
    end else begin
      num_s1    <= sw_num;
      num_s2    <= num_s1;
      cal_s1    <= sw_cal_mode;
      cal_mode  <= cal_s1;
      disp_s1   <= sw_disp_mode;
      disp_mode <= disp_s1;
    end
  end

  always_comb begin
    state_d      = state_q;
    num1_d       = num1;
    num2_d       = num2;
    load_pulse_d = 1'b0;
    ev           = encode_event(ev_clear, ev_load_a, ev_load_b);
    case (ev)
      EV_CLEAR: begin
        state_d = EMPTY;
        num1_d  = '0;
        num2_d  = '0;
      end
      EV_LOAD_A: begin
        num1_d       = num_s2;
        load_pulse_d = 1'b1;
        state_d      = (state_q == B_ONLY || state_q == BOTH) ? BOTH : A_ONLY;
      end
      EV_LOAD_B: begin
        num2_d       = num_s2;
        load_pulse_d = 1'b1;
        state_d      = (state_q == A_ONLY || state_q == BOTH) ? BOTH : B_ONLY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      num1       <= '0;
      num2       <= '0;
      ready      <= 1'b0;
      load_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      num1       <= num1_d;
      num2       <= num2_d;
      ready      <= (state_d == BOTH);
      load_pulse <= load_pulse_d;
    end
  end

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed bench for calc_operand_entry with a short debounce time.
module tb_calc_operand_entry;

  localparam int NW = 7;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NW-1:0] sw_num;
  logic          sw_cal_mode;
  logic          sw_disp_mode;
  logic          key_load_a_n;
  logic          key_load_b_n;
  logic          key_clear_n;
  logic [NW-1:0] num1;
  logic [NW-1:0] num2;
  logic          cal_mode;
  logic          disp_mode;
  logic          ready;
  logic          load_pulse;

  int vec = 0;
  int errs = 0;

  calc_operand_entry #(.NUM_W(NW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sw_num(sw_num), .sw_cal_mode(sw_cal_mode),
    .sw_disp_mode(sw_disp_mode), .key_load_a_n(key_load_a_n),
    .key_load_b_n(key_load_b_n), .key_clear_n(key_clear_n),
    .num1(num1), .num2(num2), .cal_mode(cal_mode), .disp_mode(disp_mode),
    .ready(ready), .load_pulse(load_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mask bits: [0] load_a, [1] load_b, [2] clear
  task automatic set_keys(input logic [2:0] mask);
    key_load_a_n = ~mask[0];
    key_load_b_n = ~mask[1];
    key_clear_n  = ~mask[2];
  endtask

  // Holds keys for 'hold' cycles then releases; first = edge offset of first pulse.
  task automatic press_keys(input logic [2:0] mask, input int hold,
                            output int pulses, output int first);
    pulses = 0;
    first  = -1;
    set_keys(mask);
    for (int n = 0; n < hold + 14; n++) begin
      if (n == hold) set_keys(3'b000);
      step();
      if (load_pulse === 1'b1) begin
        if (first < 0) first = n;
        pulses++;
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst_n = 1'b0; sw_num = '0; sw_cal_mode = 1'b0; sw_disp_mode = 1'b0;
    set_keys(3'b000);
    step(); step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (load_pulse !== 1'b0) pulses++;
    end
    vec++; if (pulses !== 0) begin errs++; $display("FAIL reset_idle_pulse got %0d want 0", pulses); end
    vec++; if (num1 !== 7'd0) begin errs++; $display("FAIL reset_num1 got %0d want 0", num1); end
    vec++; if (num2 !== 7'd0) begin errs++; $display("FAIL reset_num2 got %0d want 0", num2); end
    vec++; if (ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b want 0", ready); end
    vec++; if (cal_mode !== 1'b0 || disp_mode !== 1'b0) begin
      errs++; $display("FAIL reset_modes got %b%b want 00", cal_mode, disp_mode);
    end
  endtask

  task automatic test_mode_sync();
    sw_cal_mode = 1'b1; sw_disp_mode = 1'b1;
    step();
    vec++; if (cal_mode !== 1'b0 || disp_mode !== 1'b0) begin
      errs++; $display("FAIL mode_sync_1edge got %b%b want 00", cal_mode, disp_mode);
    end
    step();
    vec++; if (cal_mode !== 1'b1 || disp_mode !== 1'b1) begin
      errs++; $display("FAIL mode_sync_2edge got %b%b want 11", cal_mode, disp_mode);
    end
    sw_disp_mode = 1'b0;
    step(); step();
    vec++; if (cal_mode !== 1'b1 || disp_mode !== 1'b0) begin
      errs++; $display("FAIL mode_sync_disp_low got %b%b want 10", cal_mode, disp_mode);
    end
    sw_cal_mode = 1'b0;
    step(); step();
  endtask

  task automatic test_load_a();
    int pulses;
    logic saw_early;
    pulses = 0;
    saw_early = 1'b0;
    sw_num = 7'd25;
    set_keys(3'b001);
    for (int n = 0; n < 24; n++) begin
      if (n == 10) set_keys(3'b000);
      step();
      if (load_pulse === 1'b1) pulses++;
      if (n == 6) begin
        vec++; if (num1 !== 7'd0 || load_pulse !== 1'b0) begin
          errs++; $display("FAIL load_a_early num1 %0d pulse %b want 0 0", num1, load_pulse);
        end
      end
      if (n == 7) begin
        vec++; if (num1 !== 7'd25) begin errs++; $display("FAIL load_a_num1 got %0d want 25", num1); end
        vec++; if (load_pulse !== 1'b1) begin errs++; $display("FAIL load_a_pulse got %b want 1", load_pulse); end
        vec++; if (ready !== 1'b0 || num2 !== 7'd0) begin
          errs++; $display("FAIL load_a_other ready %b num2 %0d want 0 0", ready, num2);
        end
      end
      if (n == 8) begin
        vec++; if (load_pulse !== 1'b0) begin errs++; $display("FAIL load_a_pulse_end got %b want 0", load_pulse); end
      end
    end
    vec++; if (pulses !== 1) begin errs++; $display("FAIL load_a_pulse_count got %0d want 1", pulses); end
  endtask

  task automatic test_load_b_then_a();
    int pulses, first;
    sw_num = 7'd100;
    press_keys(3'b010, 10, pulses, first);
    vec++; if (num2 !== 7'd100) begin errs++; $display("FAIL load_b_num2 got %0d want 100", num2); end
    vec++; if (ready !== 1'b1) begin errs++; $display("FAIL load_b_ready got %b want 1", ready); end
    vec++; if (first !== 7 || pulses !== 1) begin
      errs++; $display("FAIL load_b_timing first %0d count %0d want 7 1", first, pulses);
    end
    sw_num = 7'd127;
    press_keys(3'b001, 10, pulses, first);
    vec++; if (num1 !== 7'd127) begin errs++; $display("FAIL reload_a_num1 got %0d want 127", num1); end
    vec++; if (ready !== 1'b1 || num2 !== 7'd100) begin
      errs++; $display("FAIL reload_a_keep ready %b num2 %0d want 1 100", ready, num2);
    end
  endtask

  task automatic test_glitch_bounce();
    int pulses, first;
    sw_num = 7'd3;
    press_keys(3'b001, 3, pulses, first);
    vec++; if (pulses !== 0 || num1 !== 7'd127) begin
      errs++; $display("FAIL glitch pulses %0d num1 %0d want 0 127", pulses, num1);
    end
    sw_num = 7'd127;
    pulses = 0;
    set_keys(3'b001);
    for (int n = 0; n < 30; n++) begin
      if (n >= 10 && n < 16) set_keys((n % 2 == 0) ? 3'b000 : 3'b001);
      if (n == 16) set_keys(3'b000);
      step();
      if (load_pulse === 1'b1) pulses++;
    end
    vec++; if (pulses !== 1) begin errs++; $display("FAIL bounce_release pulses got %0d want 1", pulses); end
  endtask

  task automatic test_simultaneous();
    int pulses, first;
    sw_num = 7'd55;
    press_keys(3'b111, 10, pulses, first);
    vec++; if (num1 !== 7'd0 || num2 !== 7'd0) begin
      errs++; $display("FAIL clear_wins num1 %0d num2 %0d want 0 0", num1, num2);
    end
    vec++; if (ready !== 1'b0 || pulses !== 0) begin
      errs++; $display("FAIL clear_wins ready %b pulses %0d want 0 0", ready, pulses);
    end
    press_keys(3'b011, 10, pulses, first);
    vec++; if (num1 !== 7'd55 || num2 !== 7'd0) begin
      errs++; $display("FAIL a_beats_b num1 %0d num2 %0d want 55 0", num1, num2);
    end
    vec++; if (ready !== 1'b0 || pulses !== 1) begin
      errs++; $display("FAIL a_beats_b ready %b pulses %0d want 0 1", ready, pulses);
    end
    sw_num = 7'd9;
    press_keys(3'b010, 10, pulses, first);
    vec++; if (ready !== 1'b1 || num2 !== 7'd9) begin
      errs++; $display("FAIL a_only_to_both ready %b num2 %0d want 1 9", ready, num2);
    end
  endtask

  task automatic test_reset_mid_press();
    int pulses, first;
    set_keys(3'b010);
    step(); step();
    sw_num = 7'd33;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vec++; if (num1 !== 7'd0 || num2 !== 7'd0 || ready !== 1'b0 || load_pulse !== 1'b0) begin
      errs++; $display("FAIL midreset_outputs %0d %0d %b %b want 0 0 0 0", num1, num2, ready, load_pulse);
    end
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 6) begin
        vec++; if (num2 !== 7'd0) begin errs++; $display("FAIL midreset_early num2 got %0d want 0", num2); end
      end
      if (n == 8) begin
        vec++; if (num2 !== 7'd33 || load_pulse !== 1'b1) begin
          errs++; $display("FAIL midreset_load num2 %0d pulse %b want 33 1", num2, load_pulse);
        end
        vec++; if (ready !== 1'b0 || num1 !== 7'd0) begin
          errs++; $display("FAIL midreset_state ready %b num1 %0d want 0 0", ready, num1);
        end
      end
    end
    set_keys(3'b000);
    for (int n = 0; n < 12; n++) step();
    sw_num = 7'd1;
    press_keys(3'b001, 10, pulses, first);
    vec++; if (ready !== 1'b1 || num1 !== 7'd1) begin
      errs++; $display("FAIL b_only_to_both ready %b num1 %0d want 1 1", ready, num1);
    end
  endtask

  initial begin
    test_reset();
    test_mode_sync();
    test_load_a();
    test_load_b_then_a();
    test_glitch_bounce();
    test_simultaneous();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
